// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default widths, master state encoding and
// the filler word returned when a slave never answers.
package wb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_END  = 2'd2
  } wbm_state_t;

endpackage

// File: rtl/wishbone_master.sv
// Single-transfer Wishbone classic initiator. Takes one command from a
// valid/ready port, runs one CYC/STB cycle, waits for ACK/ERR or timeout,
// and reports the result on a one-cycle response strobe.
module wishbone_master
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [DATA_W-1:0]     cmd_data_i,
  input  logic [DATA_W/8-1:0]   cmd_sel_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_W-1:0]     adr_o,
  output logic [DATA_W-1:0]     dat_o,
  input  logic [DATA_W-1:0]     dat_i,
  output logic                  we_o,
  output logic [DATA_W/8-1:0]   sel_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TO_WORD  = DATA_W'(TIMEOUT_DATA);

  wbm_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               bus_done;

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    bus_done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid_i) begin
          adr_d   = cmd_addr_i;
          dat_d   = cmd_data_i;
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // ACK wins over ERR; the timeout only fires when neither is present.
        if (ack_i) begin
          if (!we_q) rsp_data_d = dat_i;
          rsp_err_d = 1'b0;
          bus_done  = 1'b1;
        end else if (err_i) begin
          rsp_err_d = 1'b1;
          bus_done  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = TO_WORD;
          bus_done   = 1'b1;
        end
        if (bus_done) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_END;
        end
      end

      ST_END: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        // Slaves may keep ACK/ERR up until they see STB low; wait it out.
        if (!ack_i && !err_i) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign we_o        = we_q;
  assign sel_o       = sel_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Self-checking bench for wishbone_master: directed scenarios followed by
// random transactions, with the slave behaviour and expected response
// derived from a per-transaction description.
module tb_wishbone_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i;
  logic [DW/8-1:0] cmd_sel_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          we_o;
  logic [DW/8-1:0] sel_o;
  logic          cyc_o;
  logic          stb_o;
  logic          ack_i;
  logic          err_i;

  int total = 0;
  int bad   = 0;

  // Last response data the master should be presenting.
  logic [DW-1:0] model_data;

  // Fields of a command held on the port while the current one finishes.
  logic          nxt_we;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_data;
  logic [3:0]    nxt_sel;

  wishbone_master #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .cmd_sel_i  (cmd_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .we_o       (we_o),
    .sel_o      (sel_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .ack_i      (ack_i),
    .err_i      (err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one command from a negedge where cmd_ready_o should be 1 and
  // returns at the negedge where it is expected to be 1 again.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [3:0] sel,
                         input int wait_n, input int kind, input int hold,
                         input logic [DW-1:0] rdata, input bit chain);
    bit            responds;
    int            exp_stb;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    int            hold_eff;
    int            nstb;
    int            guard;
    bit            hit;

    responds = (kind != K_NONE) && (wait_n < TO);
    exp_stb  = responds ? wait_n + 1 : TO;
    exp_err  = !responds || (kind == K_ERR);
    if (!responds)                                        exp_data = 32'hDEAD_BEEF;
    else if ((kind == K_ACK || kind == K_BOTH) && !we)    exp_data = rdata;
    else                                                  exp_data = model_data;
    model_data = exp_data;
    hold_eff   = responds ? hold : 0;

    chk("ready_before_cmd", {63'd0, cmd_ready_o}, 64'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    cmd_sel_i   = sel;
    dat_i       = rdata;
    ack_i       = 1'b0;
    err_i       = 1'b0;

    @(negedge clk);
    chk("stb_after_accept", {63'd0, stb_o}, 64'd1);
    chk("ready_low_in_bus", {63'd0, cmd_ready_o}, 64'd0);

    nstb  = 0;
    guard = 0;
    while (stb_o === 1'b1 && guard < TO + 4) begin
      chk("cyc_in_bus", {63'd0, cyc_o}, 64'd1);
      chk("adr_stable", {32'd0, adr_o}, {32'd0, addr});
      chk("dat_stable", {32'd0, dat_o}, {32'd0, data});
      chk("sel_stable", {60'd0, sel_o}, {60'd0, sel});
      chk("we_stable", {63'd0, we_o}, {63'd0, we});
      chk("no_rsp_in_bus", {63'd0, rsp_valid_o}, 64'd0);
      hit   = responds && (nstb == wait_n);
      ack_i = hit && (kind == K_ACK || kind == K_BOTH);
      err_i = hit && (kind == K_ERR || kind == K_BOTH);
      // Port activity while busy must be ignored.
      cmd_valid_i = 1'($urandom_range(0, 1));
      cmd_we_i    = 1'($urandom_range(0, 1));
      cmd_addr_i  = $urandom;
      cmd_data_i  = $urandom;
      cmd_sel_i   = 4'($urandom_range(0, 15));
      nstb++;
      guard++;
      @(negedge clk);
    end

    chk("stb_cycles", 64'(nstb), 64'(exp_stb));
    chk("cyc_low_end", {63'd0, cyc_o}, 64'd0);
    chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, exp_err});
    chk("rsp_data", {32'd0, rsp_data_o}, {32'd0, exp_data});
    chk("ready_low_end", {63'd0, cmd_ready_o}, 64'd0);

    if (chain) begin
      cmd_valid_i = 1'b1;
      cmd_we_i    = nxt_we;
      cmd_addr_i  = nxt_addr;
      cmd_data_i  = nxt_data;
      cmd_sel_i   = nxt_sel;
    end else begin
      cmd_valid_i = 1'b0;
    end
    if (hold_eff == 0) begin
      ack_i = 1'b0;
      err_i = 1'b0;
    end

    for (int h = 1; h <= hold_eff; h++) begin
      @(negedge clk);
      chk("ready_low_hold", {63'd0, cmd_ready_o}, 64'd0);
      chk("rsp_one_cycle", {63'd0, rsp_valid_o}, 64'd0);
      chk("stb_low_hold", {63'd0, stb_o}, 64'd0);
      if (h == hold_eff) begin
        ack_i = 1'b0;
        err_i = 1'b0;
      end
    end

    @(negedge clk);
    chk("ready_back", {63'd0, cmd_ready_o}, 64'd1);
    chk("rsp_one_cycle_end", {63'd0, rsp_valid_o}, 64'd0);
    chk("stb_low_idle", {63'd0, stb_o}, 64'd0);
    chk("rsp_data_held", {32'd0, rsp_data_o}, {32'd0, exp_data});
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cyc"}, {63'd0, cyc_o}, 64'd0);
    chk({tag, "_stb"}, {63'd0, stb_o}, 64'd0);
    chk({tag, "_we"}, {63'd0, we_o}, 64'd0);
    chk({tag, "_adr"}, {32'd0, adr_o}, 64'd0);
    chk({tag, "_dat"}, {32'd0, dat_o}, 64'd0);
    chk({tag, "_sel"}, {60'd0, sel_o}, 64'd0);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid_o}, 64'd0);
    chk({tag, "_rsp_err"}, {63'd0, rsp_err_o}, 64'd0);
    chk({tag, "_rsp_data"}, {32'd0, rsp_data_o}, 64'd0);
    chk({tag, "_ready"}, {63'd0, cmd_ready_o}, 64'd1);
  endtask

  initial begin
    int wt;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_data_i  = '0;
    cmd_sel_i   = '0;
    dat_i       = '0;
    ack_i       = 1'b0;
    err_i       = 1'b0;
    model_data  = '0;
    nxt_we      = 1'b0;
    nxt_addr    = '0;
    nxt_data    = '0;
    nxt_sel     = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst_i = 1'b0;
    @(negedge clk);
    chk_reset_values("post_rst");

    // Read with immediate ACK.
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0, K_ACK, 0, 32'h0000_0015, 1'b0);
    // Write with three wait states; response data must not change.
    run_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 3, K_ACK, 0, 32'h1234_5678, 1'b0);
    // Silent slave: timeout.
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h3, TO + 5, K_NONE, 0, 32'h5555_AAAA, 1'b0);
    // ERR on the second STB cycle.
    run_txn(1'b0, 32'h0000_0024, 32'h0, 4'hF, 1, K_ERR, 0, 32'h7777_0000, 1'b0);
    // ACK and ERR together: ACK wins.
    run_txn(1'b0, 32'h0000_0028, 32'h0, 4'hC, 0, K_BOTH, 0, 32'h0BAD_C0DE, 1'b0);

    // ACK held two cycles after STB drops, next command held meanwhile.
    nxt_we   = 1'b1;
    nxt_addr = 32'h0000_0100;
    nxt_data = 32'hA5A5_5A5A;
    nxt_sel  = 4'h1;
    run_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 0, K_ACK, 2, 32'h0000_0099, 1'b1);
    run_txn(nxt_we, nxt_addr, nxt_data, nxt_sel, 0, K_ACK, 0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_second_accept", {63'd0, stb_o}, 64'd0);
    end

    // Reset in the second BUS cycle.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_addr_i  = 32'h0000_0200;
    cmd_data_i  = 32'hFEED_FACE;
    cmd_sel_i   = 4'hF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("rst_txn_stb0", {63'd0, stb_o}, 64'd1);
    @(negedge clk);
    chk("rst_txn_stb1", {63'd0, stb_o}, 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_data = '0;
    chk_reset_values("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
      chk("mid_rst_idle_stb", {63'd0, stb_o}, 64'd0);
    end

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) wt = $urandom_range(0, TO + 2);
      else                           wt = $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              wt, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
